// File: rtl/spi_master.sv
// Mode-0 SPI master: one 8-bit MSB-first frame per accepted start, SCK idle low,
// MOSI launched on falling SCK, MISO sampled (through a 2-flop sync) on rising SCK.
module spi_master #(
  parameter int HALF_PERIOD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] din,
  input  logic       cont,
  input  logic       miso,
  output logic       ss,
  output logic       sck,
  output logic       mosi,
  output logic       busy,
  output logic       new_data,
  output logic [7:0] dout
);

  localparam int CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [CW-1:0] HP_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [3:0] LAST_EDGE = 4'd15;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] hp_cnt_reg;
  logic [3:0]    edge_cnt_reg;
  logic [7:0]    tx_reg;
  logic [7:0]    rx_reg;
  logic          cont_reg;
  logic [1:0]    miso_sync_reg;
  logic          hp_last;

  assign hp_last = (hp_cnt_reg == HP_LAST);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:    if (start) state_next = SETUP;
      SETUP:   if (hp_last) state_next = SHIFT;
      SHIFT:   if (hp_last && edge_cnt_reg == LAST_EDGE) state_next = HOLD;
      HOLD:    if (hp_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) miso_sync_reg <= 2'b00;
    else     miso_sync_reg <= {miso_sync_reg[0], miso};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hp_cnt_reg   <= '0;
      edge_cnt_reg <= 4'd0;
      tx_reg       <= 8'h00;
      rx_reg       <= 8'h00;
      cont_reg     <= 1'b0;
      ss           <= 1'b1;
      sck          <= 1'b0;
      mosi         <= 1'b0;
      new_data     <= 1'b0;
      dout         <= 8'h00;
    end else begin
      new_data <= 1'b0;
      if (state_reg == IDLE) hp_cnt_reg <= '0;
      else                   hp_cnt_reg <= hp_last ? '0 : hp_cnt_reg + 1'b1;

      case (state_reg)
        IDLE: begin
          if (start) begin
            tx_reg       <= din;
            mosi         <= din[7];
            cont_reg     <= cont;
            ss           <= 1'b0;
            edge_cnt_reg <= 4'd0;
          end
        end
        SETUP: begin
          // The first rising edge is generated here; SHIFT handles edges 1..15.
          if (hp_last) begin
            sck          <= 1'b1;
            rx_reg       <= {rx_reg[6:0], miso_sync_reg[1]};
            edge_cnt_reg <= 4'd1;
          end
        end
        SHIFT: begin
          if (hp_last) begin
            sck          <= ~sck;
            edge_cnt_reg <= edge_cnt_reg + 4'd1;
            if (sck) begin
              if (edge_cnt_reg == LAST_EDGE) begin
                // mosi keeps bit 0; ss releases now unless the frame continues
                dout     <= rx_reg;
                new_data <= 1'b1;
                ss       <= ~cont_reg;
              end else begin
                tx_reg <= tx_reg << 1;
                mosi   <= tx_reg[6];
              end
            end else begin
              rx_reg <= {rx_reg[6:0], miso_sync_reg[1]};
            end
          end
        end
        HOLD: begin
          sck <= 1'b0;
        end
        default: begin
          sck <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spi_master.md
# spi_master

Mode-0 SPI master: the initiator that talks to the `spi_slave` protocol on this board (SCK idle low, MOSI/MISO set up on the falling edge, sampled on the rising edge, MSB first, 8-bit frames). It accepts one byte per `start` pulse, generates SS/SCK/MOSI from the system clock, shifts in MISO, and returns the received byte with a one-cycle `new_data` strobe. It sits between the host-side command logic and the off-chip or peer-FPGA SPI pins.

## Interface
- `HALF_PERIOD`, default 8: system clocks per SCK half-period. Legal values are ≥ 6, which covers peer 2-flop sync, peer register, and local MISO 2-flop sync.
- `clk` input 1: system clock; all logic on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: begin a frame; honoured only when `busy`=0.
- `din` input 8: byte to transmit; latched on an accepted `start`.
- `cont` input 1: latched with `start`; 1 keeps `ss` low after the frame.
- `miso` input 1: serial data from the slave; asynchronous to `clk`.
- `ss` output 1: active-low slave select.
- `sck` output 1: serial clock, idle 0.
- `mosi` output 1: serial data to the slave.
- `busy` output 1: frame in progress; `start` is ignored while high.
- `new_data` output 1: one-cycle strobe; `dout` is valid.
- `dout` output 8: last received byte; held until the next `new_data`.

## Operation
- **States:** IDLE, SETUP, SHIFT, HOLD.
- **Counters:** half-period counter `$clog2(HALF_PERIOD)` bits, wraps at `HALF_PERIOD-1`; edge counter 4 bits (0..15).
- **IDLE:** `busy`=0, `sck`=0. `start`=1 latches `din` into the shift register, latches `cont`, drives `ss`=0 and `mosi`=`din[7]`, then goes to SETUP.
- **SETUP:** counts `HALF_PERIOD` cycles, then raises `sck` and enters SHIFT. The count runs even if `ss` was already low from a prior `cont` frame.
- **SHIFT:** `sck` toggles every `HALF_PERIOD` cycles.
  - Rising edge (0→1): shift `miso_sync` into the receive LSB.
  - Falling edge (1→0): shift the transmit register left and drive the next MSB onto `mosi`.
  - After the 8th falling edge (16 edges total): `dout` ← received byte, `new_data`=1 for one cycle, go to HOLD.
  - `mosi` holds bit 0 after the last falling edge.
- **HOLD:** `sck`=0 for `HALF_PERIOD` cycles. `ss`=1 from entry if latched `cont`=0; otherwise `ss` stays 0. Then go to IDLE. This guarantees minimum SS-high time so the slave reloads its transmit byte.
- **MISO sync:** `miso` passes through a 2-flop synchroniser (`miso_sync`) before sampling.
- **`start` while `busy`=1:** ignored, with no queueing.
- **`start` in the same cycle as HOLD→IDLE:** ignored; accepted from the first IDLE cycle.
- **`rst`** mid-frame aborts immediately. Next cycle all outputs are at reset values and the state is IDLE; no `new_data` is produced.

## Timing
- Reset values: `ss`=1, `sck`=0, `mosi`=0, `busy`=0, `new_data`=0, `dout`=0x00.
- Timeline, with `start` sampled at cycle T and H=`HALF_PERIOD`:
  - T+1: `ss`=0, `busy`=1, `mosi`=`din[7]`.
  - Rising `sck` edges at T+1+H+2kH, k=0..7. Falling edges at T+1+2H+2kH.
  - `mosi` bit 7−k is stable from the falling edge before rising edge k (from T+1 for k=0) until the next falling edge.
  - `new_data`=1 and `dout` updated during cycle T+1+16H. `ss`=1 in the same cycle if `cont`=0.
  - `busy`=0 at T+1+17H; earliest next accepted `start` is at that cycle.
- Throughput: one byte per 17H+1 cycles.
- The value sampled at rising edge k is `miso` as it stood ≥ 2 cycles earlier.

## Test plan
- **Loopback:** `miso` tied to `mosi`, H=8, `din`=0xA5, `cont`=0, `start` at T → `dout`=0xA5 with `new_data` only at T+129; `ss` low exactly T+1..T+128; `busy` low at T+137; exactly 8 rising `sck` edges.
- **Against behavioural mode-0 slave:** H=6, slave returns 0x3C while master sends 0xC3 → master `dout`=0x3C, slave receives 0xC3; repeat with 0x00/0xFF and 0x80/0x01.
- **Continuous:** frames 0x12 (`cont`=1) then 0x34 (`cont`=0) → `ss` stays low between frames; second frame's first rising edge is H cycles after its `start`+1; both bytes are received correctly.
- **Busy guard:** extra `start` pulses with `din`=0xFF mid-frame and on the `busy`-falling cycle boundary → ignored; only the original byte is transmitted; no extra `new_data`.
- **Reset mid-frame:** `rst` after the 3rd rising edge → next cycle `ss`=1, `sck`=0, `busy`=0, `dout` unchanged from 0x00, no `new_data`; a new frame afterwards completes correctly.
- **Edge timing checker:** assert every `sck` high/low interval equals exactly H cycles, and that `mosi` never changes while `sck`=1 or within one cycle of a rising edge.
